// File: rtl/lsh_ht_ctrl.sv
// LSH hash-table request controller: forwards insert/query requests to the hash table,
// then scans the per-window count bus for the best-matching window on queries.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// ISSUE | one-cycle insert/query strobe to the hash table
// SCAN  | walking ht_count_bus one entry per cycle, tracking the max
// RESP  | response held until rsp_ready
module lsh_ht_ctrl #(
   parameter int NUM_WINDOWS = 1024,
   parameter int SKETCH_S    = 16,
   parameter int MAX_INSERTS = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_op,
   input  logic [31:0]               req_window_id,
   input  logic [8*SKETCH_S-1:0]     req_sketch,
   output logic                      ht_is_insert,
   output logic                      ht_is_query,
   output logic [31:0]               ht_window_id,
   output logic [8*SKETCH_S-1:0]     ht_hashed_sketch,
   input  logic [32*NUM_WINDOWS-1:0] ht_count_bus,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_op,
   output logic                      rsp_error,
   output logic                      rsp_hit,
   output logic [31:0]               rsp_best_id,
   output logic [31:0]               rsp_best_count,
   output logic [31:0]               insert_count,
   output logic                      busy
);

   localparam int IW = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
   localparam int SW = 8*SKETCH_S;

   typedef enum logic [1:0] {IDLE, ISSUE, SCAN, RESP} state_t;

   state_t          state_q, state_d;
   logic            op_q, op_d;
   logic            err_q, err_d;
   logic [31:0]     win_q, win_d;
   logic [SW-1:0]   sketch_q, sketch_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [31:0]     best_cnt_q, best_cnt_d;
   logic [31:0]     best_id_q, best_id_d;
   logic [31:0]     icnt_q, icnt_d;
   logic [31:0]     cur_cnt;
   logic            reject;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         op_q       <= 1'b0;
         err_q      <= 1'b0;
         win_q      <= '0;
         sketch_q   <= '0;
         idx_q      <= '0;
         best_cnt_q <= '0;
         best_id_q  <= '0;
         icnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         err_q      <= err_d;
         win_q      <= win_d;
         sketch_q   <= sketch_d;
         idx_q      <= idx_d;
         best_cnt_q <= best_cnt_d;
         best_id_q  <= best_id_d;
         icnt_q     <= icnt_d;
      end
   end

   assign cur_cnt = ht_count_bus[32*idx_q +: 32];
   assign reject  = !req_op && ((req_window_id >= 32'(NUM_WINDOWS)) ||
                                (icnt_q >= 32'(MAX_INSERTS)));

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      err_d      = err_q;
      win_d      = win_q;
      sketch_d   = sketch_q;
      idx_d      = idx_q;
      best_cnt_d = best_cnt_q;
      best_id_d  = best_id_q;
      icnt_d     = icnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d       = req_op;
               err_d      = reject;
               idx_d      = '0;
               best_cnt_d = '0;
               best_id_d  = '0;
               // Rejected inserts leave the hash-table outputs at their last values.
               if (reject) begin
                  state_d = RESP;
               end else begin
                  win_d    = req_window_id;
                  sketch_d = req_sketch;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (op_q) begin
               state_d = SCAN;
            end else begin
               if (icnt_q < 32'(MAX_INSERTS)) icnt_d = icnt_q + 32'd1;
               state_d = RESP;
            end
         end
         SCAN: begin
            if (cur_cnt > best_cnt_q) begin
               best_cnt_d = cur_cnt;
               best_id_d  = 32'(idx_q);
            end
            if (idx_q == IW'(NUM_WINDOWS-1)) state_d = RESP;
            else                             idx_d   = idx_q + 1'b1;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Gated with reset_n so every output reads 0 while reset is held.
   assign req_ready        = (state_q == IDLE) && reset_n;
   assign busy             = (state_q != IDLE);
   assign ht_is_insert     = (state_q == ISSUE) && !op_q;
   assign ht_is_query      = (state_q == ISSUE) && op_q;
   assign ht_window_id     = win_q;
   assign ht_hashed_sketch = sketch_q;
   assign rsp_valid        = (state_q == RESP);
   assign rsp_op           = op_q;
   assign rsp_error        = err_q;
   assign rsp_hit          = op_q && (best_cnt_q != 32'd0);
   assign rsp_best_id      = best_id_q;
   assign rsp_best_count   = best_cnt_q;
   assign insert_count     = icnt_q;

endmodule

// File: tb/tb_lsh_ht_ctrl.sv
// Directed bench for lsh_ht_ctrl with NUM_WINDOWS=8, MAX_INSERTS=2: request table plus
// hand-written reset-abort sequences.
module tb_lsh_ht_ctrl;

   localparam int NW = 8;
   localparam int SK = 16;
   localparam int MI = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_op = 1'b0;
   logic [31:0]     req_window_id = '0;
   logic [8*SK-1:0] req_sketch = '0;
   logic            ht_is_insert, ht_is_query;
   logic [31:0]     ht_window_id;
   logic [8*SK-1:0] ht_hashed_sketch;
   logic [32*NW-1:0] ht_count_bus = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic            rsp_op, rsp_error, rsp_hit;
   logic [31:0]     rsp_best_id, rsp_best_count, insert_count;
   logic            busy;

   int checks = 0;
   int errors = 0;

   lsh_ht_ctrl #(.NUM_WINDOWS(NW), .SKETCH_S(SK), .MAX_INSERTS(MI)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_window_id(req_window_id), .req_sketch(req_sketch),
      .ht_is_insert(ht_is_insert), .ht_is_query(ht_is_query),
      .ht_window_id(ht_window_id), .ht_hashed_sketch(ht_hashed_sketch),
      .ht_count_bus(ht_count_bus),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_error(rsp_error), .rsp_hit(rsp_hit), .rsp_best_id(rsp_best_id),
      .rsp_best_count(rsp_best_count), .insert_count(insert_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          op;
      logic [31:0]   id;
      logic [255:0]  bus;
      int            hold;
      logic          err;
      logic          hit;
      logic [31:0]   bid;
      logic [31:0]   bcnt;
      int            icnt;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk(input int c0, c1, c2, c3, c4, c5, c6, c7);
      return {32'(c7), 32'(c6), 32'(c5), 32'(c4), 32'(c3), 32'(c2), 32'(c1), 32'(c0)};
   endfunction

   function automatic vec_t mkv(input logic op, input logic [31:0] id, input logic [255:0] bus,
                                input int hold, input logic err, input logic hit,
                                input logic [31:0] bid, input logic [31:0] bcnt, input int icnt);
      vec_t v;
      v.op = op; v.id = id; v.bus = bus; v.hold = hold; v.err = err;
      v.hit = hit; v.bid = bid; v.bcnt = bcnt; v.icnt = icnt;
      return v;
   endfunction

   task automatic run_req(input vec_t v, input string tag);
      logic [8*SK-1:0] sk;
      int lat, nstb, exp_lat;
      logic [127:0] snap;
      sk = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_lat = v.err ? 1 : (v.op ? NW + 2 : 2);
      @(negedge clk);
      req_valid = 1'b1; req_op = v.op; req_window_id = v.id; req_sketch = sk;
      ht_count_bus = v.bus; rsp_ready = 1'b0;
      chk({tag, " req_ready"}, 128'(req_ready), 128'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; nstb = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (ht_is_insert || ht_is_query) begin
            nstb++;
            chk({tag, " strobe_cycle"}, 128'(k), 128'(1));
            chk({tag, " strobe_kind"}, 128'({ht_is_insert, ht_is_query}), 128'({!v.op, v.op}));
            chk({tag, " ht_sketch"}, 128'(ht_hashed_sketch), 128'(sk));
            if (!v.op) chk({tag, " ht_window_id"}, 128'(ht_window_id), 128'(v.id));
         end
         if (rsp_valid) begin lat = k; break; end
      end
      if (lat == 0) chk({tag, " rsp_timeout"}, 128'(0), 128'(1));
      chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, " strobes"}, 128'(nstb), 128'(v.err ? 0 : 1));
      snap = {rsp_op, rsp_error, rsp_hit, rsp_best_id, rsp_best_count};
      chk({tag, " rsp_fields"}, snap, 128'({v.op, v.err, v.hit, v.bid, v.bcnt}));
      chk({tag, " insert_count"}, 128'(insert_count), 128'(v.icnt));
      chk({tag, " busy_ready"}, 128'({busy, req_ready}), 128'(2'b10));
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         chk({tag, " hold_stable"},
             128'({rsp_valid, req_ready, rsp_op, rsp_error, rsp_hit, rsp_best_id, rsp_best_count}),
             128'({1'b1, 1'b0, v.op, v.err, v.hit, v.bid, v.bcnt}));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, " rsp_done"}, 128'({rsp_valid, req_ready, busy}), 128'(3'b010));
   endtask

   task automatic abort_check(input string tag);
      reset_n = 1'b0;
      #1;
      chk({tag, " outputs_in_reset"},
          128'({ht_is_insert, ht_is_query, rsp_valid, busy, req_ready, insert_count}), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk({tag, " after_release"}, 128'({req_ready, busy}), 128'(2'b10));
   endtask

   initial begin
      vecs[0] = mkv(1'b0, 32'd8, '0, 0, 1'b1, 1'b0, 0, 0, 0);
      vecs[1] = mkv(1'b0, 32'd3, '0, 0, 1'b0, 1'b0, 0, 0, 1);
      vecs[2] = mkv(1'b0, 32'd4, '0, 0, 1'b0, 1'b0, 0, 0, 2);
      vecs[3] = mkv(1'b0, 32'd5, '0, 0, 1'b1, 1'b0, 0, 0, 2);
      vecs[4] = mkv(1'b1, 32'd0, mk(0, 2, 5, 5, 1, 0, 0, 3), 0, 1'b0, 1'b1, 2, 5, 2);
      vecs[5] = mkv(1'b1, 32'd0, mk(0, 0, 0, 0, 0, 0, 0, 0), 5, 1'b0, 1'b0, 0, 0, 2);
      vecs[6] = mkv(1'b1, 32'd0, mk(7, 0, 0, 0, 0, 0, 0, 7), 2, 1'b0, 1'b1, 0, 7, 2);
      vecs[7] = mkv(1'b1, 32'd0, mk(1, 2, 3, 4, 5, 6, 7, 9), 0, 1'b0, 1'b1, 7, 9, 2);
      vecs[8] = mkv(1'b1, 32'd0, mk(0, 0, 0, 0, 0, 0, 0, -1), 0, 1'b0, 1'b1, 7, 32'hFFFF_FFFF, 2);

      #12;
      chk("reset_outputs",
          128'({req_ready, busy, rsp_valid, ht_is_insert, ht_is_query, insert_count}), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post_reset_ready_busy", 128'({req_ready, busy}), 128'(2'b10));

      for (int i = 0; i < 9; i++) run_req(vecs[i], $sformatf("vec%0d", i));

      // Reset while the query strobe is high.
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b1; ht_count_bus = mk(0, 2, 5, 5, 1, 0, 0, 3);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_issue strobe_before", 128'(ht_is_query), 128'(1));
      abort_check("abort_issue");

      // Reset while scanning, then confirm normal operation resumes.
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_scan busy_before", 128'({busy, rsp_valid}), 128'(2'b10));
      abort_check("abort_scan");
      run_req(mkv(1'b1, 32'd0, mk(0, 2, 5, 5, 1, 0, 0, 3), 0, 1'b0, 1'b1, 2, 5, 0), "post_abort_q");
      run_req(mkv(1'b0, 32'd7, '0, 0, 1'b0, 1'b0, 0, 0, 1), "post_abort_ins");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
